pipa_moding_sim: RTL and testbench

- Parametrised multi-channel PIPA pulse simulator for the FPGA AGC top level.
- Converts the AGC's PIPASW/PIPDAT interrogation pair into per-channel plus/minus PIPA pulse trains.
- Channel count and moding cycle length are parameters. Each channel has a programmable net-acceleration bias, latched only at cycle boundaries.
- PIPASW is sampled with a synchronous edge detect on the system clock rather than used as a clock. Per-channel signed pulse accumulators are provided for monitor readback.

---
 rtl/pipa_pkg.sv | 23 ++
 rtl/pipa_channel.sv | 76 +++++++
 rtl/pipa_moding_sim.sv | 90 +++++++++
 tb/tb_pipa_moding_sim.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipa_pkg.sv
// Shared constants and helpers for the PIPA moding simulator.
// Default sizing plus the bias clamp used when a bias field is captured.
package pipa_pkg;

  localparam int unsigned NCHAN_DFLT  = 3;
  localparam int unsigned CYCLE_DFLT  = 6;
  localparam int unsigned BIAS_W_DFLT = 3;
  localparam int unsigned ACC_W_DFLT  = 16;
  localparam int unsigned PHASE_W     = $clog2(CYCLE_DFLT);

  // Clamp a sign-extended bias field to [-lim, +lim].
  function automatic int clamp_bias(input int value, input int lim);
    int res;
    res = value;
    if (value > lim) begin
      res = lim;
    end else if (value < -lim) begin
      res = -lim;
    end
    return res;
  endfunction

endpackage

// File: rtl/pipa_channel.sv
// One accelerometer channel: shadow/active bias, plus/minus phase split,
// pulse gating and the signed pulse accumulator.
module pipa_channel
  import pipa_pkg::*;
#(
  parameter int unsigned CYCLE  = CYCLE_DFLT,
  parameter int unsigned BIAS_W = BIAS_W_DFLT,
  parameter int unsigned ACC_W  = ACC_W_DFLT,
  parameter int unsigned PH_W   = PHASE_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_pipdat,
  input  logic              i_dat_rise,
  input  logic              i_wrap,
  input  logic              i_bias_load,
  input  logic              i_acc_clr,
  input  logic [BIAS_W-1:0] i_bias,
  input  logic [PH_W-1:0]   i_phase,
  output logic              o_pipa_p,
  output logic              o_pipa_m,
  output logic [ACC_W-1:0]  o_acc
);

  localparam int unsigned HALF = CYCLE / 2;
  // One extra bit holds +/-CYCLE/2; two extra bits hold plus_n up to CYCLE.
  localparam int unsigned BB_W = PH_W + 1;
  localparam int unsigned PN_W = PH_W + 2;

  logic signed [BB_W-1:0] w_clamped;
  logic signed [BB_W-1:0] r_shadow;
  logic signed [BB_W-1:0] r_active;
  logic        [PN_W-1:0] w_plus_n;
  logic                   w_in_plus;
  logic                   w_gate;
  logic        [ACC_W-1:0] r_acc;

  assign w_clamped = BB_W'(clamp_bias(int'($signed(i_bias)), int'(HALF)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow <= '0;
    end else if (i_bias_load) begin
      r_shadow <= w_clamped;
    end
  end

  // A load coinciding with the wrap bypasses the shadow so it governs the new cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_active <= '0;
    end else if (i_wrap) begin
      r_active <= i_bias_load ? w_clamped : r_shadow;
    end
  end

  assign w_plus_n  = PN_W'(HALF) + PN_W'(r_active);
  assign w_in_plus = PN_W'(i_phase) < w_plus_n;
  assign w_gate    = i_enable & i_pipdat;
  assign o_pipa_p  = w_gate & w_in_plus;
  assign o_pipa_m  = w_gate & ~w_in_plus;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else if (i_acc_clr) begin
      r_acc <= '0;
    end else if (i_enable && i_dat_rise) begin
      r_acc <= o_pipa_p ? (r_acc + ACC_W'(1)) : (r_acc - ACC_W'(1));
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/pipa_moding_sim.sv
// Multi-channel PIPA pulse simulator: samples PIPASW/PIPDAT edges on prop_clk,
// runs the moding phase counter and fans out to per-channel pulse generators.
module pipa_moding_sim
  import pipa_pkg::*;
#(
  parameter int unsigned NCHAN  = NCHAN_DFLT,
  parameter int unsigned CYCLE  = CYCLE_DFLT,
  parameter int unsigned BIAS_W = BIAS_W_DFLT,
  parameter int unsigned ACC_W  = ACC_W_DFLT
) (
  input  logic                      prop_clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      pipasw,
  input  logic                      pipdat,
  input  logic [NCHAN*BIAS_W-1:0]   bias,
  input  logic                      bias_load,
  output logic [NCHAN-1:0]          pipa_p,
  output logic [NCHAN-1:0]          pipa_m,
  output logic [$clog2(CYCLE)-1:0]  phase,
  output logic                      cycle_done,
  output logic [NCHAN*ACC_W-1:0]    acc,
  input  logic                      acc_clr
);

  localparam int unsigned PH_W = $clog2(CYCLE);
  localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(CYCLE - 1);

  logic            r_pipasw_d;
  logic            r_pipdat_d;
  logic [PH_W-1:0] r_phase;
  logic            r_cycle_done;
  logic            w_sw_rise;
  logic            w_dat_rise;
  logic            w_wrap;

  // Edge history tracks continuously so re-enabling never fabricates an edge.
  always_ff @(posedge prop_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipasw_d <= 1'b0;
      r_pipdat_d <= 1'b0;
    end else begin
      r_pipasw_d <= pipasw;
      r_pipdat_d <= pipdat;
    end
  end

  assign w_sw_rise  = pipasw & ~r_pipasw_d;
  assign w_dat_rise = pipdat & ~r_pipdat_d;
  assign w_wrap     = enable & w_sw_rise & (r_phase == LAST_PHASE);

  always_ff @(posedge prop_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase      <= '0;
      r_cycle_done <= 1'b0;
    end else begin
      r_cycle_done <= w_wrap;
      if (enable && w_sw_rise) begin
        r_phase <= w_wrap ? '0 : (r_phase + PH_W'(1));
      end
    end
  end

  assign phase      = r_phase;
  assign cycle_done = r_cycle_done;

  for (genvar c = 0; c < int'(NCHAN); c++) begin : g_chan
    pipa_channel #(
      .CYCLE  (CYCLE),
      .BIAS_W (BIAS_W),
      .ACC_W  (ACC_W),
      .PH_W   (PH_W)
    ) u_chan (
      .i_clk       (prop_clk),
      .i_rst_n     (rst_n),
      .i_enable    (enable),
      .i_pipdat    (pipdat),
      .i_dat_rise  (w_dat_rise),
      .i_wrap      (w_wrap),
      .i_bias_load (bias_load),
      .i_acc_clr   (acc_clr),
      .i_bias      (bias[c*BIAS_W +: BIAS_W]),
      .i_phase     (r_phase),
      .o_pipa_p    (pipa_p[c]),
      .o_pipa_m    (pipa_m[c]),
      .o_acc       (acc[c*ACC_W +: ACC_W])
    );
  end

endmodule

// File: tb/tb_pipa_moding_sim.sv
// Bench for pipa_moding_sim: a default build plus a BIAS_W=4/ACC_W=8 build,
// both checked against an event-level model of the moding rules.
module tb_pipa_moding_sim;

  localparam int NCH  = 3;
  localparam int CYC  = 6;
  localparam int HALF = CYC / 2;

  logic        clk = 1'b0;
  logic        rst_n, enable, pipasw, pipdat, bias_load, acc_clr;
  logic [8:0]  bias_a;
  logic [11:0] bias_b;
  logic [2:0]  p_a, m_a, p_b, m_b, ph_a, ph_b;
  logic        cd_a, cd_b;
  logic [47:0] acc_a;
  logic [23:0] acc_b;

  int total = 0;
  int bad   = 0;

  // Model state
  int m_phase;
  bit m_sw_d, m_dat_d, m_cd;
  int m_shadow [2][NCH];
  int m_active [2][NCH];
  int m_acc    [2][NCH];
  bit e_cd, g_cd;

  always #5 clk = ~clk;

  pipa_moding_sim u_dut_a (
    .prop_clk(clk), .rst_n(rst_n), .enable(enable), .pipasw(pipasw), .pipdat(pipdat),
    .bias(bias_a), .bias_load(bias_load), .pipa_p(p_a), .pipa_m(m_a), .phase(ph_a),
    .cycle_done(cd_a), .acc(acc_a), .acc_clr(acc_clr)
  );

  pipa_moding_sim #(.BIAS_W(4), .ACC_W(8)) u_dut_b (
    .prop_clk(clk), .rst_n(rst_n), .enable(enable), .pipasw(pipasw), .pipdat(pipdat),
    .bias(bias_b), .bias_load(bias_load), .pipa_p(p_b), .pipa_m(m_b), .phase(ph_b),
    .cycle_done(cd_b), .acc(acc_b), .acc_clr(acc_clr)
  );

  function automatic int accw(int i);
    return (i == 0) ? 16 : 8;
  endfunction

  function automatic int fld(int i, int c);
    logic signed [2:0] a;
    logic signed [3:0] b;
    a = bias_a[c*3 +: 3];
    b = bias_b[c*4 +: 4];
    return (i == 0) ? int'(a) : int'(b);
  endfunction

  function automatic int clampf(int v);
    return (v > HALF) ? HALF : ((v < -HALF) ? -HALF : v);
  endfunction

  function automatic logic [2:0] exp_p(int i);
    logic [2:0] r;
    for (int c = 0; c < NCH; c++) r[c] = enable && pipdat && (m_phase < HALF + m_active[i][c]);
    return r;
  endfunction

  function automatic logic [2:0] exp_m(int i);
    logic [2:0] r;
    for (int c = 0; c < NCH; c++) r[c] = enable && pipdat && (m_phase >= HALF + m_active[i][c]);
    return r;
  endfunction

  function automatic int get_acc(int i, int c);
    return (i == 0) ? int'(acc_a[c*16 +: 16]) : int'(acc_b[c*8 +: 8]);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_sw_d = 0; m_dat_d = 0; m_cd = 0;
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < NCH; c++) begin
        m_shadow[i][c] = 0; m_active[i][c] = 0; m_acc[i][c] = 0;
      end
  endtask

  // Advance one clock: model next state from the present inputs, then the edge.
  task automatic step();
    int n_sh [2][NCH];
    int n_act[2][NCH];
    int n_acc[2][NCH];
    int n_phase;
    bit swr, datr, wrap, pl;
    swr  = pipasw && !m_sw_d;
    datr = pipdat && !m_dat_d;
    wrap = enable && swr && (m_phase == CYC - 1);
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < NCH; c++) begin
        pl = enable && pipdat && (m_phase < HALF + m_active[i][c]);
        n_acc[i][c] = acc_clr ? 0 :
                      ((enable && datr) ? ((m_acc[i][c] + (pl ? 1 : -1)) & ((1 << accw(i)) - 1))
                                        : m_acc[i][c]);
        n_sh[i][c]  = bias_load ? clampf(fld(i, c)) : m_shadow[i][c];
        n_act[i][c] = wrap ? (bias_load ? clampf(fld(i, c)) : m_shadow[i][c]) : m_active[i][c];
      end
    n_phase = (enable && swr) ? (wrap ? 0 : m_phase + 1) : m_phase;
    @(posedge clk);
    m_shadow = n_sh; m_active = n_act; m_acc = n_acc;
    m_phase = n_phase; m_cd = wrap; m_sw_d = pipasw; m_dat_d = pipdat;
    #1;
  endtask

  task automatic pulse_sw(input bit ld);
    pipasw = 1'b1; bias_load = ld;
    step();
    g_cd = cd_a; e_cd = m_cd;
    bias_load = 1'b0; pipasw = 1'b0;
    step();
  endtask

  task automatic end_dat();
    step();
    pipdat = 1'b0;
    step();
  endtask

  task automatic goto_phase(input int ph);
    for (int n = 0; n < CYC && m_phase != ph; n++) pulse_sw(1'b0);
    total++;
    if (ph_a !== 3'(ph)) begin
      bad++; $display("FAIL goto_phase got=%0d want=%0d", ph_a, ph);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; pipasw = 1'b0; pipdat = 1'b0;
    bias_a = '0; bias_b = '0; bias_load = 1'b0; acc_clr = 1'b0;
    model_reset();
    #12;
    total++; if (ph_a !== 3'd0)  begin bad++; $display("FAIL reset_phase got=%0d want=0", ph_a); end
    total++; if (cd_a !== 1'b0)  begin bad++; $display("FAIL reset_cd got=%0b want=0", cd_a); end
    total++; if (acc_a !== 48'd0) begin bad++; $display("FAIL reset_acc_a got=%0h want=0", acc_a); end
    total++; if (acc_b !== 24'd0) begin bad++; $display("FAIL reset_acc_b got=%0h want=0", acc_b); end
    total++; if ({p_a, m_a} !== 6'd0) begin bad++; $display("FAIL reset_pulses got=%0h want=0", {p_a, m_a}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_legacy();
    int ncd = 0;
    int ph;
    logic [2:0] ep;
    enable = 1'b1;
    for (int k = 0; k < 12; k++) begin
      ph = k % CYC;
      ep = (ph < 3) ? 3'b111 : 3'b000;
      pipdat = 1'b1; #1;
      total++; if (ph_a !== 3'(ph)) begin bad++; $display("FAIL legacy_phase k=%0d got=%0d want=%0d", k, ph_a, ph); end
      total++; if (p_a !== ep || m_a !== ~ep) begin bad++; $display("FAIL legacy_pm k=%0d got=%b/%b want=%b/%b", k, p_a, m_a, ep, ~ep); end
      total++; if (p_b !== ep) begin bad++; $display("FAIL legacy_p_b k=%0d got=%b want=%b", k, p_b, ep); end
      end_dat();
      pulse_sw(1'b0);
      if (g_cd) ncd++;
      total++; if (g_cd !== (ph == CYC - 1)) begin bad++; $display("FAIL legacy_cd k=%0d got=%b want=%b", k, g_cd, ph == CYC - 1); end
    end
    total++; if (ncd != 2) begin bad++; $display("FAIL legacy_cd_count got=%0d want=2", ncd); end
    total++; if (acc_a !== 48'd0 || acc_b !== 24'd0) begin bad++; $display("FAIL legacy_acc got=%0h/%0h want=0", acc_a, acc_b); end
  endtask

  task automatic test_biased();
    int np[NCH];
    bias_a = {3'd3, 3'b111, 3'd2};
    bias_b = {4'd2, 4'b1000, 4'd7};
    bias_load = 1'b1; step(); bias_load = 1'b0;
    for (int k = 0; k < CYC; k++) pulse_sw(1'b0);
    acc_clr = 1'b1; step(); acc_clr = 1'b0;
    for (int c = 0; c < NCH; c++) np[c] = 0;
    for (int k = 0; k < CYC; k++) begin
      pipdat = 1'b1; #1;
      for (int c = 0; c < NCH; c++) if (p_a[c]) np[c]++;
      total++; if (p_a !== exp_p(0) || m_b !== exp_m(1)) begin bad++; $display("FAIL biased_pm k=%0d got=%b/%b want=%b/%b", k, p_a, m_b, exp_p(0), exp_m(1)); end
      end_dat();
      pulse_sw(1'b0);
    end
    total++; if (np[0] != 5 || np[1] != 2 || np[2] != 6) begin bad++; $display("FAIL biased_plus_count got=%0d,%0d,%0d want=5,2,6", np[0], np[1], np[2]); end
    total++; if (acc_a !== {16'd6, 16'hFFFE, 16'd4}) begin bad++; $display("FAIL biased_acc_a got=%h want=%h", acc_a, {16'd6, 16'hFFFE, 16'd4}); end
    total++; if (acc_b !== {8'd4, 8'hFA, 8'd6}) begin bad++; $display("FAIL clamp_acc_b got=%h want=%h", acc_b, {8'd4, 8'hFA, 8'd6}); end
  endtask

  task automatic test_deferred();
    int ph;
    bit ep;
    bias_a = '0; bias_b = '0;
    bias_load = 1'b1; step(); bias_load = 1'b0;
    for (int k = 0; k < CYC; k++) pulse_sw(1'b0);
    goto_phase(2);
    bias_a = 9'd1;
    bias_load = 1'b1; step(); bias_load = 1'b0;
    for (int k = 0; k < 10; k++) begin
      ph = (2 + k) % CYC;
      ep = (k < 4) ? (ph < 3) : (ph < 4);
      pipdat = 1'b1; #1;
      total++; if (p_a[0] !== ep || m_a[0] !== !ep) begin bad++; $display("FAIL deferred k=%0d got=%b/%b want=%b", k, p_a[0], m_a[0], ep); end
      end_dat();
      pulse_sw(1'b0);
    end
  endtask

  task automatic test_same_clock_load();
    int ph;
    bias_a = 9'b000_000_101;
    goto_phase(CYC - 1);
    pulse_sw(1'b1);
    total++; if (g_cd !== 1'b1) begin bad++; $display("FAIL same_clk_cd got=%b want=1", g_cd); end
    for (int k = 0; k < CYC; k++) begin
      ph = k;
      pipdat = 1'b1; #1;
      total++; if (p_a[0] !== 1'b0 || m_a[0] !== 1'b1 || p_a[1] !== (ph < 3)) begin bad++; $display("FAIL same_clk k=%0d got=%b/%b want=0/1", k, p_a, m_a); end
      end_dat();
      pulse_sw(1'b0);
    end
  endtask

  task automatic test_acc_wrap();
    bias_b = {4'd7, 4'd7, 4'd7};
    goto_phase(CYC - 1);
    pulse_sw(1'b1);
    acc_clr = 1'b1; step(); acc_clr = 1'b0;
    for (int k = 0; k < 127; k++) begin pipdat = 1'b1; end_dat(); end
    total++; if (acc_b !== {3{8'h7F}}) begin bad++; $display("FAIL acc_at_max got=%h want=7f7f7f", acc_b); end
    pipdat = 1'b1; end_dat();
    total++; if (acc_b !== {3{8'h80}}) begin bad++; $display("FAIL acc_wrap got=%h want=808080", acc_b); end
    for (int c = 0; c < NCH; c++) begin
      total++; if (get_acc(0, c) != m_acc[0][c]) begin bad++; $display("FAIL acc_a_model c=%0d got=%0h want=%0h", c, get_acc(0, c), m_acc[0][c]); end
    end
    pipdat = 1'b1; acc_clr = 1'b1; step(); acc_clr = 1'b0;
    total++; if (acc_a !== 48'd0 || acc_b !== 24'd0) begin bad++; $display("FAIL clr_priority got=%h/%h want=0", acc_a, acc_b); end
    pipdat = 1'b0; step();
  endtask

  task automatic test_enable();
    int ph0;
    int snap[NCH];
    ph0 = m_phase;
    for (int c = 0; c < NCH; c++) snap[c] = m_acc[0][c];
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pipdat = 1'b1; #1;
      total++; if ({p_a, m_a, p_b, m_b} !== 12'd0) begin bad++; $display("FAIL disabled_pulses k=%0d got=%h want=0", k, {p_a, m_a, p_b, m_b}); end
      end_dat();
      pulse_sw(1'b0);
    end
    total++; if (ph_a !== 3'(ph0)) begin bad++; $display("FAIL disabled_phase got=%0d want=%0d", ph_a, ph0); end
    for (int c = 0; c < NCH; c++) begin
      total++; if (get_acc(0, c) != snap[c]) begin bad++; $display("FAIL disabled_acc c=%0d got=%0h want=%0h", c, get_acc(0, c), snap[c]); end
    end
    pipasw = 1'b1; step();
    enable = 1'b1; step(); step();
    total++; if (ph_a !== 3'(ph0)) begin bad++; $display("FAIL reenable_phase got=%0d want=%0d", ph_a, ph0); end
    pipasw = 1'b0; step();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      pipasw    = ($urandom % 3) == 0;
      pipdat    = ($urandom % 3) == 0;
      bias_a    = 9'($urandom);
      bias_b    = 12'($urandom);
      bias_load = ($urandom % 8) == 0;
      acc_clr   = ($urandom % 60) == 0;
      enable    = ($urandom % 10) != 0;
      #1;
      total++; if (p_a !== exp_p(0) || m_a !== exp_m(0)) begin bad++; $display("FAIL rand_pm_a k=%0d got=%b/%b want=%b/%b", k, p_a, m_a, exp_p(0), exp_m(0)); end
      total++; if (p_b !== exp_p(1) || m_b !== exp_m(1)) begin bad++; $display("FAIL rand_pm_b k=%0d got=%b/%b want=%b/%b", k, p_b, m_b, exp_p(1), exp_m(1)); end
      total++; if (ph_a !== 3'(m_phase) || ph_b !== 3'(m_phase)) begin bad++; $display("FAIL rand_phase k=%0d got=%0d/%0d want=%0d", k, ph_a, ph_b, m_phase); end
      total++; if (cd_a !== m_cd || cd_b !== m_cd) begin bad++; $display("FAIL rand_cd k=%0d got=%b/%b want=%b", k, cd_a, cd_b, m_cd); end
      for (int i = 0; i < 2; i++)
        for (int c = 0; c < NCH; c++) begin
          total++; if (get_acc(i, c) != m_acc[i][c]) begin bad++; $display("FAIL rand_acc k=%0d i=%0d c=%0d got=%0h want=%0h", k, i, c, get_acc(i, c), m_acc[i][c]); end
        end
      step();
    end
    pipasw = 1'b0; pipdat = 1'b0; bias_load = 1'b0; acc_clr = 1'b0; enable = 1'b1;
    step(); step();
  endtask

  task automatic test_reset_mid();
    bias_a = '0;
    pipdat = 1'b1; end_dat();
    goto_phase(4);
    #2; rst_n = 1'b0; #1;
    model_reset();
    total++; if (ph_a !== 3'd0) begin bad++; $display("FAIL midreset_phase got=%0d want=0", ph_a); end
    total++; if (acc_a !== 48'd0 || acc_b !== 24'd0) begin bad++; $display("FAIL midreset_acc got=%h/%h want=0", acc_a, acc_b); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    pulse_sw(1'b0);
    total++; if (ph_a !== 3'd1) begin bad++; $display("FAIL midreset_next got=%0d want=1", ph_a); end
  endtask

  initial begin
    test_reset();
    test_legacy();
    test_biased();
    test_deferred();
    test_same_clock_load();
    test_acc_wrap();
    test_enable();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
